// File: rtl/gsm_cell_serializer.sv
// Bit-serial transmitter for one GSM switch ingress port: takes a parallel cell,
// shifts it out MSB first, then issues a one-cycle valid/header strobe.
module gsm_cell_serializer #(
  parameter int DWIDTH     = 256,
  parameter int LOG_DWIDTH = 8,
  parameter int GAP        = 2
) (
  input  logic              clk_80M,
  input  logic              clr_80M,
  input  logic              i_cell_valid,
  input  logic              i_cell_header,
  input  logic [DWIDTH-1:0] i_cell_data,
  output logic              o_cell_ready,
  input  logic              i_stall,
  output logic              o_valid,
  output logic              o_header,
  output logic              o_data_bit,
  output logic              o_busy,
  output logic [15:0]       o_cell_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STROBE,
    ST_GAP
  } state_t;

  localparam logic [LOG_DWIDTH-1:0] LAST_BIT = LOG_DWIDTH'(DWIDTH - 1);
  localparam logic [LOG_DWIDTH-1:0] LAST_GAP = LOG_DWIDTH'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic                  GAP_EN   = (GAP > 0);

  state_t                state_q, state_d;
  logic [DWIDTH-1:0]     sreg_q, sreg_d;
  logic [LOG_DWIDTH-1:0] cnt_q, cnt_d;
  logic                  hdr_q, hdr_d;
  logic                  data_bit_q, data_bit_d;
  logic                  valid_q, valid_d;
  logic                  header_q, header_d;
  logic                  busy_q, busy_d;
  logic [15:0]           count_q, count_d;
  logic                  accept;

  // Back-to-back acceptance from STROBE only exists without an idle gap.
  assign o_cell_ready = !i_stall && ((state_q == ST_IDLE) ||
                                     ((state_q == ST_STROBE) && !GAP_EN));
  assign accept       = i_cell_valid && o_cell_ready;

  always_ff @(posedge clk_80M) begin
    if (clr_80M) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      hdr_q      <= 1'b0;
      data_bit_q <= 1'b0;
      valid_q    <= 1'b0;
      header_q   <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      data_bit_q <= data_bit_d;
      valid_q    <= valid_d;
      header_q   <= header_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_BIT) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (GAP_EN)      state_d = ST_GAP;
        else if (accept) state_d = ST_SHIFT;
        else             state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (cnt_q == LAST_GAP) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The MSB goes straight to the output flop on accept, so the register only
  // keeps the remaining bits and the first bit appears on the following cycle.
  always_comb begin
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    data_bit_d = 1'b0;
    valid_d    = 1'b0;
    header_d   = 1'b0;
    count_d    = count_q;

    if (accept) begin
      sreg_d     = {i_cell_data[DWIDTH-2:0], 1'b0};
      hdr_d      = i_cell_header;
      cnt_d      = '0;
      data_bit_d = i_cell_data[DWIDTH-1];
    end

    case (state_q)
      ST_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          valid_d  = 1'b1;
          header_d = hdr_q;
          count_d  = count_q + 16'd1;
        end else begin
          data_bit_d = sreg_q[DWIDTH-1];
          sreg_d     = sreg_q << 1;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      ST_STROBE: begin
        if (GAP_EN) cnt_d = '0;
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign o_valid      = valid_q;
  assign o_header     = header_q;
  assign o_data_bit   = data_bit_q;
  assign o_busy       = busy_q;
  assign o_cell_count = count_q;

endmodule

// File: tb/tb_gsm_cell_serializer.sv
// Self-checking bench: two serializers (GAP=2 and GAP=0) feeding loopback
// receive shift registers, scored against a queue of accepted cells.
module tb_gsm_cell_serializer;

  localparam int DW   = 256;
  localparam int NDUT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr[NDUT];
  logic          cell_valid[NDUT];
  logic          cell_header[NDUT];
  logic          stall[NDUT];
  logic [DW-1:0] cell_data[NDUT];
  logic          cell_ready[NDUT];
  logic          ovalid[NDUT];
  logic          oheader[NDUT];
  logic          obit[NDUT];
  logic          obusy[NDUT];
  logic [15:0]   ocount[NDUT];

  gsm_cell_serializer #(.DWIDTH(DW), .LOG_DWIDTH(8), .GAP(2)) dut_a (
    .clk_80M(clk), .clr_80M(clr[0]), .i_cell_valid(cell_valid[0]),
    .i_cell_header(cell_header[0]), .i_cell_data(cell_data[0]),
    .o_cell_ready(cell_ready[0]), .i_stall(stall[0]), .o_valid(ovalid[0]),
    .o_header(oheader[0]), .o_data_bit(obit[0]), .o_busy(obusy[0]),
    .o_cell_count(ocount[0])
  );

  gsm_cell_serializer #(.DWIDTH(DW), .LOG_DWIDTH(8), .GAP(0)) dut_b (
    .clk_80M(clk), .clr_80M(clr[1]), .i_cell_valid(cell_valid[1]),
    .i_cell_header(cell_header[1]), .i_cell_data(cell_data[1]),
    .o_cell_ready(cell_ready[1]), .i_stall(stall[1]), .o_valid(ovalid[1]),
    .o_header(oheader[1]), .o_data_bit(obit[1]), .o_busy(obusy[1]),
    .o_cell_count(ocount[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mdl_count[NDUT];
  int          pending[NDUT];
  int          strobe_prev[NDUT];
  int          spacing_seen[NDUT];
  int          expect_period[NDUT];

  typedef struct {
    logic [DW-1:0] data;
    logic          hdr;
    int            due;
  } exp_cell_t;

  typedef struct {
    logic valid;
    logic stall;
    logic exp_ready;
    logic exp_busy;
  } vec_t;

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Receiver model: shifts in one bit every cycle; on a strobe the last DW bits
  // must be the oldest accepted cell, arriving DW+1 cycles after its accept.
  for (genvar g = 0; g < NDUT; g++) begin : mon
    exp_cell_t     sb[$];
    logic [DW-1:0] rx = '0;

    always @(negedge clk) begin : mon_proc
      exp_cell_t e;
      if (clr[g]) begin
        sb.delete();
        mdl_count[g] = 16'd0;
      end else begin
        checkOutput("header_qualified", DW'(oheader[g] & ~ovalid[g]), '0);
        if (ovalid[g]) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_strobe", DW'(1), '0);
          end else begin
            e = sb.pop_front();
            mdl_count[g] = mdl_count[g] + 16'd1;
            checkOutput("rx_cell", rx, e.data);
            checkOutput("rx_header", DW'(oheader[g]), DW'(e.hdr));
            checkOutput("strobe_cycle", DW'(cyc), DW'(e.due));
            checkOutput("cell_count", DW'(ocount[g]), DW'(mdl_count[g]));
            checkOutput("strobe_bit", DW'(obit[g]), '0);
          end
          if (expect_period[g] != 0) begin
            if (strobe_prev[g] >= 0) begin
              spacing_seen[g]++;
              checkOutput("strobe_spacing", DW'(cyc - strobe_prev[g]), DW'(expect_period[g]));
            end
            strobe_prev[g] = cyc;
          end
        end
        if (cell_valid[g] && cell_ready[g]) begin
          e.data = cell_data[g];
          e.hdr  = cell_header[g];
          e.due  = cyc + DW + 1;
          sb.push_back(e);
        end
      end
      pending[g] = sb.size();
      rx = {rx[DW-2:0], obit[g]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] randCell();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic doReset(input int d);
    clr[d] = 1'b1;
    tick();
    tick();
    clr[d] = 1'b0;
  endtask

  // Offers a cell and holds it until accepted; returns one cycle after accept.
  task automatic sendCell(input int d, input logic [DW-1:0] data, input logic hdr,
                          input bit rand_stall);
    bit acc = 1'b0;
    cell_valid[d]  = 1'b1;
    cell_data[d]   = data;
    cell_header[d] = hdr;
    for (int i = 0; i < 2000 && !acc; i++) begin
      stall[d] = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
      #1;
      acc = cell_ready[d];
      tick();
    end
    stall[d] = 1'b0;
    checkOutput("accept_in_time", DW'(acc), DW'(1));
  endtask

  task automatic applyStimulus(input int d, input vec_t v);
    doReset(d);
    cell_valid[d] = v.valid;
    stall[d]      = v.stall;
    cell_data[d]  = randCell();
    #1;
    checkOutput("tbl_ready", DW'(cell_ready[d]), DW'(v.exp_ready));
    tick();
    checkOutput("tbl_busy", DW'(obusy[d]), DW'(v.exp_busy));
    cell_valid[d] = 1'b0;
    stall[d]      = 1'b0;
    doReset(d);
  endtask

  task automatic loopback(input int d, input int n);
    logic [DW-1:0] c;
    for (int i = 0; i < n; i++) begin
      if (i == 0)      c = '1;
      else if (i == 1) c = DW'(1);
      else             c = randCell();
      sendCell(d, c, 1'($urandom_range(0, 1)), 1'b1);
      cell_valid[d]  = 1'b0;
      cell_data[d]   = randCell();
      cell_header[d] = ~cell_header[d];
      repeat ($urandom_range(0, 3)) begin
        stall[d] = 1'($urandom_range(0, 1));
        tick();
      end
      stall[d] = 1'b0;
    end
    repeat (DW + 10) tick();
  endtask

  task automatic measureSpacing(input int d, input int n, input int period);
    strobe_prev[d]   = -1;
    spacing_seen[d]  = 0;
    expect_period[d] = period;
    for (int i = 0; i < n; i++) sendCell(d, randCell(), 1'($urandom_range(0, 1)), 1'b0);
    cell_valid[d] = 1'b0;
    repeat (DW + 10) tick();
    expect_period[d] = 0;
    checkOutput("spacing_samples", DW'(spacing_seen[d]), DW'(n - 1));
  endtask

  initial begin
    #(10 * 95000);
    $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t          vecs[4];
    logic [DW-1:0] c;
    int            errs;
    bit            seen;

    vecs[0] = '{valid: 1'b1, stall: 1'b0, exp_ready: 1'b1, exp_busy: 1'b1};
    vecs[1] = '{valid: 1'b1, stall: 1'b1, exp_ready: 1'b0, exp_busy: 1'b0};
    vecs[2] = '{valid: 1'b0, stall: 1'b0, exp_ready: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{valid: 1'b0, stall: 1'b1, exp_ready: 1'b0, exp_busy: 1'b0};

    for (int d = 0; d < NDUT; d++) begin
      clr[d] = 1'b1; cell_valid[d] = 1'b0; cell_header[d] = 1'b0;
      stall[d] = 1'b0; cell_data[d] = '0; mdl_count[d] = 16'd0;
      pending[d] = 0; strobe_prev[d] = -1; spacing_seen[d] = 0; expect_period[d] = 0;
    end
    tick();
    tick();
    for (int d = 0; d < NDUT; d++) clr[d] = 1'b0;
    #1;

    $display("[TB] reset values");
    for (int d = 0; d < NDUT; d++) begin
      checkOutput("rst_valid", DW'(ovalid[d]), '0);
      checkOutput("rst_header", DW'(oheader[d]), '0);
      checkOutput("rst_data_bit", DW'(obit[d]), '0);
      checkOutput("rst_busy", DW'(obusy[d]), '0);
      checkOutput("rst_count", DW'(ocount[d]), '0);
    end

    $display("[TB] handshake table");
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 4; i++) applyStimulus(d, vecs[i]);

    $display("[TB] single cell");
    c = '0;
    c[DW-1] = 1'b1;
    c[0] = 1'b1;
    sendCell(0, c, 1'b1, 1'b0);
    cell_valid[0] = 1'b0;
    checkOutput("sc_first_bit", DW'(obit[0]), DW'(1));
    checkOutput("sc_busy", DW'(obusy[0]), DW'(1));
    errs = 0;
    for (int k = 2; k <= 255; k++) begin
      tick();
      if (obit[0] !== 1'b0 || ovalid[0] !== 1'b0) errs++;
    end
    checkOutput("sc_middle_bits", DW'(errs), '0);
    tick();
    checkOutput("sc_last_bit", DW'(obit[0]), DW'(1));
    checkOutput("sc_no_early_valid", DW'(ovalid[0]), '0);
    tick();
    checkOutput("sc_strobe_valid", DW'(ovalid[0]), DW'(1));
    checkOutput("sc_strobe_header", DW'(oheader[0]), DW'(1));
    checkOutput("sc_strobe_count", DW'(ocount[0]), DW'(1));
    checkOutput("sc_strobe_bit", DW'(obit[0]), '0);
    tick();
    checkOutput("sc_valid_drop", DW'(ovalid[0]), '0);
    checkOutput("sc_header_drop", DW'(oheader[0]), '0);

    $display("[TB] stall in idle, toggled stall during shift");
    for (int i = 0; i < 20 && obusy[0]; i++) tick();
    cell_valid[0] = 1'b1;
    cell_data[0] = randCell();
    cell_header[0] = 1'b0;
    stall[0] = 1'b1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cell_ready[0] !== 1'b0 || obusy[0] !== 1'b0 || obit[0] !== 1'b0) errs++;
    end
    checkOutput("stall_blocks_accept", DW'(errs), '0);
    stall[0] = 1'b0;
    #1;
    checkOutput("stall_release_ready", DW'(cell_ready[0]), DW'(1));
    tick();
    checkOutput("stall_release_busy", DW'(obusy[0]), DW'(1));
    cell_valid[0] = 1'b0;
    cell_data[0] = randCell();
    for (int i = 0; i < DW; i++) begin
      stall[0] = 1'($urandom_range(0, 1));
      tick();
    end
    stall[0] = 1'b0;
    repeat (10) tick();

    $display("[TB] loopback GAP=2");
    loopback(0, 100);

    $display("[TB] strobe spacing");
    measureSpacing(0, 4, DW + 2 + 2);
    doReset(1);
    measureSpacing(1, 4, DW + 1);

    $display("[TB] reset mid-cell");
    sendCell(0, randCell(), 1'b1, 1'b0);
    cell_valid[0] = 1'b0;
    repeat (99) tick();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    checkOutput("abort_valid", DW'(ovalid[0]), '0);
    checkOutput("abort_header", DW'(oheader[0]), '0);
    checkOutput("abort_data_bit", DW'(obit[0]), '0);
    checkOutput("abort_busy", DW'(obusy[0]), '0);
    checkOutput("abort_count", DW'(ocount[0]), '0);
    seen = 1'b0;
    repeat (DW + 40) begin
      tick();
      if (ovalid[0]) seen = 1'b1;
    end
    checkOutput("abort_no_strobe", DW'(seen), '0);
    sendCell(0, randCell(), 1'b0, 1'b0);
    cell_valid[0] = 1'b0;
    repeat (DW + 10) tick();
    checkOutput("post_abort_count", DW'(ocount[0]), DW'(1));

    $display("[TB] loopback GAP=0");
    loopback(1, 20);

    $display("[TB] count wrap");
    force dut_b.count_q = 16'hFFFF;
    tick();
    release dut_b.count_q;
    mdl_count[1] = 16'hFFFF;
    sendCell(1, randCell(), 1'b1, 1'b0);
    cell_valid[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (ovalid[1]) seen = 1'b1;
    end
    checkOutput("wrap_strobe_seen", DW'(seen), DW'(1));
    checkOutput("wrap_count", DW'(ocount[1]), '0);

    repeat (10) tick();
    checkOutput("pending_a", DW'(pending[0]), '0);
    checkOutput("pending_b", DW'(pending[1]), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
